// File: rtl/muldiv_pkg.sv
// Shared constants, state encoding and opcode helpers for the multiply/divide controller.
package muldiv_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [5:0] OpMul    = 6'b101001;
  localparam logic [5:0] OpMulh   = 6'b101010;
  localparam logic [5:0] OpMulhsu = 6'b101011;
  localparam logic [5:0] OpMulhu  = 6'b101100;
  localparam logic [5:0] OpDiv    = 6'b101101;
  localparam logic [5:0] OpDivu   = 6'b101110;
  localparam logic [5:0] OpRem    = 6'b101111;
  localparam logic [5:0] OpRemu   = 6'b110000;

  typedef enum logic [2:0] {
    StIdle,
    StCalc,
    StDiv,
    StFix,
    StDone
  } state_e;

  function automatic logic is_valid_op(input logic [5:0] op);
    return op inside {OpMul, OpMulh, OpMulhsu, OpMulhu, OpDiv, OpDivu, OpRem, OpRemu};
  endfunction

  function automatic logic is_div_op(input logic [5:0] op);
    return op inside {OpDiv, OpDivu, OpRem, OpRemu};
  endfunction

  function automatic logic is_signed_div(input logic [5:0] op);
    return op inside {OpDiv, OpRem};
  endfunction

  function automatic logic is_rem_op(input logic [5:0] op);
    return op inside {OpRem, OpRemu};
  endfunction

endpackage

// File: rtl/muldiv_ctrl_div_iter.sv
// Restoring divider datapath: one quotient bit per enabled cycle on unsigned magnitudes.
module div_iter #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load_i,
  input  logic            en_i,
  input  logic [XLEN-1:0] dividend_i,
  input  logic [XLEN-1:0] divisor_i,
  output logic [XLEN-1:0] quotient_o,
  output logic [XLEN-1:0] remainder_o
);

  logic [XLEN-1:0] rem_q, rem_d;
  logic [XLEN-1:0] quo_q, quo_d;
  logic [XLEN:0]   shifted;
  logic [XLEN:0]   trial;

  // The quotient register starts out holding the dividend and shifts it into the remainder.
  always_comb begin
    rem_d   = rem_q;
    quo_d   = quo_q;
    shifted = {rem_q, quo_q[XLEN-1]};
    trial   = shifted - {1'b0, divisor_i};
    if (load_i) begin
      rem_d = '0;
      quo_d = dividend_i;
    end else if (en_i) begin
      if (trial[XLEN]) begin
        rem_d = shifted[XLEN-1:0];
        quo_d = {quo_q[XLEN-2:0], 1'b0};
      end else begin
        rem_d = trial[XLEN-1:0];
        quo_d = {quo_q[XLEN-2:0], 1'b1};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q <= '0;
      quo_q <= '0;
    end else begin
      rem_q <= rem_d;
      quo_q <= quo_d;
    end
  end

  assign quotient_o  = quo_q;
  assign remainder_o = rem_q;

endmodule

// File: rtl/muldiv_ctrl.sv
// RV32M-style multiply/divide controller: single-cycle multiply and special cases,
// 32-step restoring division with sign fix-up, registered busy/done/result.
module muldiv_ctrl #(
  parameter int unsigned XLEN = muldiv_pkg::XLEN
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [5:0]      aluSelect,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  import muldiv_pkg::*;

  localparam int unsigned CntW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MinInt = {1'b1, {(XLEN-1){1'b0}}};

  state_e            state_q;
  logic [5:0]        op_q;
  logic [XLEN-1:0]   rs1_q, rs2_q;
  logic [CntW-1:0]   cnt_q;
  logic              busy_q, done_q;
  logic [XLEN-1:0]   result_q;

  logic              can_accept, accept, special;
  logic [XLEN-1:0]   dividend_mag, divisor_mag;
  logic [XLEN-1:0]   quotient, remainder;
  logic [2*XLEN-1:0] mul_a, mul_b, product;
  logic              sign_a, sign_b, q_neg, r_neg;
  logic [XLEN-1:0]   calc_res, fix_res;

  // Decode of the incoming request; special cases finish in CALC without iterating.
  always_comb begin
    can_accept   = (state_q == StIdle) || (state_q == StDone);
    accept       = start && is_valid_op(aluSelect) && can_accept;
    special      = !is_div_op(aluSelect) || (rs2 == '0) ||
                   (is_signed_div(aluSelect) && (rs1 == MinInt) && (rs2 == '1));
    dividend_mag = (is_signed_div(aluSelect) && rs1[XLEN-1]) ? -rs1 : rs1;
    divisor_mag  = (is_signed_div(op_q) && rs2_q[XLEN-1]) ? -rs2_q : rs2_q;
  end

  div_iter #(
    .XLEN (XLEN)
  ) u_div_iter (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_i      (accept && !special && !flush),
    .en_i        (state_q == StDiv),
    .dividend_i  (dividend_mag),
    .divisor_i   (divisor_mag),
    .quotient_o  (quotient),
    .remainder_o (remainder)
  );

  // Multiply via sign-extended double-width operands covers s*s, s*u and u*u alike.
  always_comb begin
    sign_a   = (op_q == OpMulh) || (op_q == OpMulhsu);
    sign_b   = (op_q == OpMulh);
    mul_a    = {{XLEN{sign_a & rs1_q[XLEN-1]}}, rs1_q};
    mul_b    = {{XLEN{sign_b & rs2_q[XLEN-1]}}, rs2_q};
    product  = mul_a * mul_b;
    calc_res = '0;
    case (op_q)
      OpMul:                      calc_res = product[XLEN-1:0];
      OpMulh, OpMulhsu, OpMulhu:  calc_res = product[2*XLEN-1:XLEN];
      OpDiv, OpDivu:              calc_res = (rs2_q == '0) ? '1 : MinInt;
      OpRem, OpRemu:              calc_res = (rs2_q == '0) ? rs1_q : '0;
      default:                    calc_res = '0;
    endcase
  end

  always_comb begin
    q_neg   = is_signed_div(op_q) && (rs1_q[XLEN-1] ^ rs2_q[XLEN-1]);
    r_neg   = is_signed_div(op_q) && rs1_q[XLEN-1];
    fix_res = is_rem_op(op_q) ? (r_neg ? -remainder : remainder)
                              : (q_neg ? -quotient : quotient);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      op_q     <= '0;
      rs1_q    <= '0;
      rs2_q    <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else if (flush) begin
      state_q <= StIdle;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle, StDone: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
          if (accept) begin
            op_q   <= aluSelect;
            rs1_q  <= rs1;
            rs2_q  <= rs2;
            busy_q <= 1'b1;
            if (special) begin
              state_q <= StCalc;
            end else begin
              state_q <= StDiv;
              cnt_q   <= CntW'(XLEN - 1);
            end
          end
        end
        StCalc: begin
          state_q  <= StDone;
          busy_q   <= 1'b0;
          done_q   <= 1'b1;
          result_q <= calc_res;
        end
        StDiv: begin
          if (cnt_q == '0) begin
            state_q <= StFix;
          end else begin
            cnt_q <= cnt_q - CntW'(1);
          end
        end
        StFix: begin
          state_q  <= StDone;
          busy_q   <= 1'b0;
          done_q   <= 1'b1;
          result_q <= fix_res;
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl: directed vector table, randomized ops vs. an
// arithmetic reference model, and hand-written flush/busy/reset sequences.
module tb_muldiv_ctrl;
  import muldiv_pkg::*;

  localparam logic [31:0] MinInt = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [5:0]  alu_sel;
  logic [31:0] rs1_v, rs2_v;
  logic        flush;
  logic        busy, done;
  logic [31:0] result;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  muldiv_ctrl #(
    .XLEN (32)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .aluSelect (alu_sel),
    .rs1       (rs1_v),
    .rs2       (rs2_v),
    .flush     (flush),
    .busy      (busy),
    .done      (done),
    .result    (result)
  );

  typedef struct {
    string       name;
    logic [5:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_res;
    int          exp_lat;
  } vec_t;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference result straight from the arithmetic definitions, using 64-bit math.
  function automatic logic [31:0] ref_res(input logic [5:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    logic signed [31:0] as_, bs_;
    longint sa, sb, ua, ub, p;
    logic [63:0] pu;
    as_ = a;
    bs_ = b;
    sa = as_;
    sb = bs_;
    ua = {32'b0, a};
    ub = {32'b0, b};
    case (op)
      OpMul:    begin p = sa * sb; return p[31:0]; end
      OpMulh:   begin p = sa * sb; return p[63:32]; end
      OpMulhsu: begin p = sa * ub; return p[63:32]; end
      OpMulhu:  begin pu = ua * ub; return pu[63:32]; end
      OpDiv:    begin if (b == 0) return 32'hFFFF_FFFF; p = sa / sb; return p[31:0]; end
      OpDivu:   begin if (b == 0) return 32'hFFFF_FFFF; p = ua / ub; return p[31:0]; end
      OpRem:    begin if (b == 0) return a; p = sa % sb; return p[31:0]; end
      OpRemu:   begin if (b == 0) return a; p = ua % ub; return p[31:0]; end
      default:  return 32'h0;
    endcase
  endfunction

  function automatic int ref_lat(input logic [5:0] op, input logic [31:0] a,
                                 input logic [31:0] b);
    if (op inside {OpMul, OpMulh, OpMulhsu, OpMulhu}) return 2;
    if (b == 0) return 2;
    if ((op == OpDiv || op == OpRem) && a == MinInt && b == 32'hFFFF_FFFF) return 2;
    return 34;
  endfunction

  // Issue in the current cycle (cycle 0) and wait, bounded, for done.
  task automatic run_op(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output logic [31:0] res, output logic busy1);
    start   = 1'b1;
    alu_sel = op;
    rs1_v   = a;
    rs2_v   = b;
    tick();
    start   = 1'b0;
    alu_sel = 6'd0;
    lat     = 1;
    busy1   = busy;
    while (!done && lat < 60) begin
      tick();
      lat++;
    end
    res = result;
  endtask

  initial begin
    vec_t        vecs[$];
    logic [5:0]  codes[8];
    int          lat;
    logic [31:0] res;
    logic        b1;
    logic [31:0] last_res;
    logic        seen_done;

    codes = '{OpMul, OpMulh, OpMulhsu, OpMulhu, OpDiv, OpDivu, OpRem, OpRemu};
    vecs.push_back('{"mul_6x7",     OpMul,    32'd6,          32'd7,          32'd42,         2});
    vecs.push_back('{"div_m100_25", OpDiv,    -32'sd100,      32'd25,         32'hFFFF_FFFC,  34});
    vecs.push_back('{"rem_m101_20", OpRem,    -32'sd101,      32'd20,         32'hFFFF_FFFF,  34});
    vecs.push_back('{"remu_101_20", OpRemu,   32'd101,        32'd20,         32'd1,          34});
    vecs.push_back('{"div_by0",     OpDiv,    32'd123,        32'd0,          32'hFFFF_FFFF,  2});
    vecs.push_back('{"rem_by0",     OpRem,    32'd123,        32'd0,          32'd123,        2});
    vecs.push_back('{"div_ovf",     OpDiv,    MinInt,         32'hFFFF_FFFF,  MinInt,         2});
    vecs.push_back('{"rem_ovf",     OpRem,    MinInt,         32'hFFFF_FFFF,  32'd0,          2});
    vecs.push_back('{"divu_by0",    OpDivu,   32'd100,        32'd0,          32'hFFFF_FFFF,  2});
    vecs.push_back('{"remu_by0",    OpRemu,   32'd5,          32'd0,          32'd5,          2});
    vecs.push_back('{"mulh_m1m1",   OpMulh,   32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd0,          2});
    vecs.push_back('{"mulhsu_m1",   OpMulhsu, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFF,  2});
    vecs.push_back('{"mulhu_max",   OpMulhu,  32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE,  2});
    vecs.push_back('{"divu_max_1",  OpDivu,   32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  34});
    vecs.push_back('{"div_m7_2",    OpDiv,    -32'sd7,        32'd2,          32'hFFFF_FFFD,  34});
    vecs.push_back('{"rem_7_m2",    OpRem,    32'd7,          -32'sd2,        32'd1,          34});

    rst_n = 1'b0; start = 1'b0; flush = 1'b0; alu_sel = 6'd0; rs1_v = '0; rs2_v = '0;
    #2;
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_result", result, 0);
    tick();
    tick();
    rst_n = 1'b1;

    // Table vectors; each one issues in the previous op's DONE cycle (back-to-back).
    foreach (vecs[i]) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, lat, res, b1);
      check({vecs[i].name, "_res"}, res, vecs[i].exp_res);
      check({vecs[i].name, "_lat"}, lat, vecs[i].exp_lat);
      check({vecs[i].name, "_busy1"}, b1, 1);
    end
    last_res = 32'd1;

    // Randomized operations against the reference model.
    for (int i = 0; i < 30; i++) begin
      logic [5:0]  op;
      logic [31:0] a, b;
      int          r;
      op = codes[$urandom_range(0, 7)];
      a  = $urandom;
      b  = $urandom;
      r  = $urandom_range(0, 9);
      if (r == 0) b = 32'd0;
      else if (r == 1) begin a = MinInt; b = 32'hFFFF_FFFF; end
      else if (r == 2) b = $urandom_range(1, 20);
      else if (r == 3) a = -$urandom_range(1, 1000);
      run_op(op, a, b, lat, res, b1);
      check($sformatf("rand%0d_op%0h_res", i, op), res, ref_res(op, a, b));
      check($sformatf("rand%0d_op%0h_lat", i, op), lat, ref_lat(op, a, b));
      last_res = ref_res(op, a, b);
    end
    tick();

    // Flush DIVU in cycle 10, then MUL issued in cycle 11 completes in cycle 13.
    seen_done = 1'b0;
    start = 1'b1; alu_sel = OpDivu; rs1_v = 32'd100; rs2_v = 32'd25;
    tick();
    start = 1'b0;
    for (int c = 1; c < 10; c++) begin
      if (done) seen_done = 1'b1;
      tick();
    end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_busy_c11", busy, 0);
    check("flush_no_done", seen_done | done, 0);
    check("flush_result_kept", result, last_res);
    start = 1'b1; alu_sel = OpMul; rs1_v = 32'd3; rs2_v = 32'd5;
    tick();
    start = 1'b0;
    check("post_flush_busy_c12", busy, 1);
    check("post_flush_done_c12", done, 0);
    tick();
    check("post_flush_done_c13", done, 1);
    check("post_flush_res", result, 15);
    tick();

    // Flush wins over a simultaneous start.
    flush = 1'b1; start = 1'b1; alu_sel = OpMul; rs1_v = 32'd2; rs2_v = 32'd2;
    tick();
    flush = 1'b0; start = 1'b0;
    check("flush_prio_busy", busy, 0);
    tick();
    check("flush_prio_done", done, 0);
    check("flush_prio_res", result, 15);

    // Start while busy is ignored; MULHU issued in the DONE cycle is accepted.
    seen_done = 1'b0;
    start = 1'b1; alu_sel = OpDiv; rs1_v = 32'd1000; rs2_v = 32'd7;
    tick();
    start = 1'b0;
    lat = 1;
    while (!done && lat < 60) begin
      if (lat == 5) begin
        start = 1'b1; alu_sel = OpMulhu; rs1_v = 32'd50000; rs2_v = 32'd100000;
      end
      tick();
      start = 1'b0;
      lat++;
    end
    check("busy_ignore_lat", lat, 34);
    check("busy_ignore_res", result, 142);
    start = 1'b1; alu_sel = OpMulhu; rs1_v = 32'd50000; rs2_v = 32'd100000;
    tick();
    start = 1'b0;
    check("b2b_busy", busy, 1);
    check("b2b_done_early", done, 0);
    tick();
    check("b2b_done", done, 1);
    check("b2b_res", result, 1);
    tick();

    // Reset in cycle 20 of a DIV clears outputs at once; nothing completes afterwards.
    start = 1'b1; alu_sel = OpDiv; rs1_v = 32'd999; rs2_v = 32'd3;
    tick();
    start = 1'b0;
    for (int c = 1; c < 20; c++) tick();
    rst_n = 1'b0;
    #1;
    check("rst_mid_busy", busy, 0);
    check("rst_mid_done", done, 0);
    check("rst_mid_result", result, 0);
    tick();
    rst_n = 1'b1;
    seen_done = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (done || busy) seen_done = 1'b1;
      tick();
    end
    check("rst_no_done_after", seen_done, 0);

    // First accept right after reset release.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    run_op(OpMul, 32'd6, 32'd7, lat, res, b1);
    check("first_accept_lat", lat, 2);
    check("first_accept_res", res, 42);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
